// File: rtl/tft_pclk_monitor_pkg.sv
// Shared definitions for the TFT pixel-clock receive monitor.
package tft_pclk_monitor_pkg;

  localparam int PCLK_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } pclk_state_t;

  // Magnitude of the difference between two counter values, one bit wider so nothing wraps.
  function automatic logic [PCLK_CNT_WIDTH:0] abs_diff(
    input logic [PCLK_CNT_WIDTH-1:0] a,
    input logic [PCLK_CNT_WIDTH-1:0] b
  );
    logic [PCLK_CNT_WIDTH:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[PCLK_CNT_WIDTH]) begin
      d = -d;
    end
    return d;
  endfunction

endpackage

// File: rtl/tft_pclk_edge_sync.sv
// Brings pclk_in into the clk domain and emits registered one-cycle edge strobes.
module tft_pclk_edge_sync
  import tft_pclk_monitor_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic pclk_in,
  output logic rise,
  output logic fall,
  output logic pclk_edge
);

  logic s1;
  logic s2;
  logic prev;

  // Two-flop synchronizer, one-cycle-delayed copy, and registered edge decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      prev      <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
      pclk_edge <= 1'b0;
    end else begin
      s1        <= pclk_in;
      s2        <= s1;
      prev      <= s2;
      rise      <= s2 & ~prev;
      fall      <= ~s2 & prev;
      pclk_edge <= s2 ^ prev;
    end
  end

endmodule

// File: rtl/tft_pclk_monitor.sv
// Recovers the pixel-clock divide value from edge spacing and reports lock / loss.
module tft_pclk_monitor
  import tft_pclk_monitor_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TOLERANCE  = 0,
  parameter logic [15:0] TIMEOUT    = 16'hFFF0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pclk_in,
  output logic                      rise_strobe,
  output logic                      fall_strobe,
  output logic [PCLK_CNT_WIDTH-1:0] measured_divide,
  output logic                      lock,
  output logic                      lost
);

  localparam logic [3:0]                LOCK_COUNT_W = LOCK_COUNT[3:0];
  localparam logic [PCLK_CNT_WIDTH:0]   TOLERANCE_W  = TOLERANCE[PCLK_CNT_WIDTH:0];
  localparam logic [PCLK_CNT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT - 16'd1;

  logic                      rise;
  logic                      fall;
  logic                      pclk_edge;
  pclk_state_t               state_q;
  pclk_state_t               state_d;
  logic [PCLK_CNT_WIDTH-1:0] half_cnt;
  logic [3:0]                match_q;
  logic [3:0]                match_d;
  logic [PCLK_CNT_WIDTH-1:0] ref_val;
  logic [PCLK_CNT_WIDTH-1:0] ref_d;
  logic [PCLK_CNT_WIDTH-1:0] meas_d;
  logic [PCLK_CNT_WIDTH:0]   deviation;
  logic                      timeout_hit;

  tft_pclk_edge_sync u_edge_sync (
    .clk       (clk),
    .rst       (rst),
    .pclk_in   (pclk_in),
    .rise      (rise),
    .fall      (fall),
    .pclk_edge (pclk_edge)
  );

  assign rise_strobe = rise;
  assign fall_strobe = fall;
  assign lock        = (state_q == LOCKED);
  assign lost        = (state_q == LOST);
  assign deviation   = abs_diff(half_cnt, ref_val);
  assign timeout_hit = (half_cnt == TIMEOUT_LAST);

  // Half-period counter: restarts on every edge, otherwise counts up and sticks at full scale.
  always_ff @(posedge clk) begin
    if (rst) begin
      half_cnt <= '0;
    end else if (pclk_edge) begin
      half_cnt <= '0;
    end else if (half_cnt != {PCLK_CNT_WIDTH{1'b1}}) begin
      half_cnt <= half_cnt + 16'd1;
    end
  end

  // State, match run length, reference interval and the published divide value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      match_q         <= '0;
      ref_val         <= '0;
      measured_divide <= '0;
    end else begin
      state_q         <= state_d;
      match_q         <= match_d;
      ref_val         <= ref_d;
      measured_divide <= meas_d;
    end
  end

  // Next-state logic: an edge always wins over a coincident timeout.
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    ref_d   = ref_val;
    meas_d  = measured_divide;
    case (state_q)
      IDLE: begin
        if (pclk_edge) begin
          state_d = ACQUIRE;
          match_d = 4'd0;
        end
      end
      ACQUIRE: begin
        if (pclk_edge) begin
          if ((match_q == 4'd0) || (half_cnt != ref_val)) begin
            ref_d   = half_cnt;
            match_d = 4'd1;
          end else begin
            match_d = match_q + 4'd1;
          end
          if (match_d == LOCK_COUNT_W) begin
            state_d = LOCKED;
            meas_d  = ref_d;
          end
        end else if (timeout_hit) begin
          state_d = LOST;
        end
      end
      LOCKED: begin
        if (pclk_edge) begin
          if (deviation > TOLERANCE_W) begin
            state_d = ACQUIRE;
            ref_d   = half_cnt;
            match_d = 4'd1;
          end
        end else if (timeout_hit) begin
          state_d = LOST;
        end
      end
      LOST: begin
        if (pclk_edge) begin
          state_d = ACQUIRE;
          match_d = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tft_pclk_monitor.sv
// Self-checking bench: hand-written strobe table, directed scenarios, random stimulus vs. a reference model.
module tb_tft_pclk_monitor;

  localparam int          LC = 4;
  localparam logic [15:0] TO = 16'd40;

  logic        clk;
  logic        rst;
  logic        pclk_in;
  logic [1:0]  rise_s;
  logic [1:0]  fall_s;
  logic [1:0]  lock_s;
  logic [1:0]  lost_s;
  logic [15:0] meas_s [2];

  int checks;
  int failures;

  // Instance 0 has zero tolerance, instance 1 tolerates one cycle of jitter.
  tft_pclk_monitor #(.LOCK_COUNT(LC), .TOLERANCE(0), .TIMEOUT(TO)) dut0 (
    .clk             (clk),
    .rst             (rst),
    .pclk_in         (pclk_in),
    .rise_strobe     (rise_s[0]),
    .fall_strobe     (fall_s[0]),
    .measured_divide (meas_s[0]),
    .lock            (lock_s[0]),
    .lost            (lost_s[0])
  );

  tft_pclk_monitor #(.LOCK_COUNT(LC), .TOLERANCE(1), .TIMEOUT(TO)) dut1 (
    .clk             (clk),
    .rst             (rst),
    .pclk_in         (pclk_in),
    .rise_strobe     (rise_s[1]),
    .fall_strobe     (fall_s[1]),
    .measured_divide (meas_s[1]),
    .lock            (lock_s[1]),
    .lost            (lost_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: sample history of pclk_in plus an interval-list view of each monitor.
  typedef enum int {M_IDLE, M_ACQ, M_LOCKED, M_LOST} mstate_t;
  mstate_t    mst [2];
  int         meas_m [2];
  int         tol_m [2];
  int         ivl [2][16];
  int         ivl_n [2];
  logic [4:0] hist;
  int         cyc;
  int         last_edge;
  logic       exp_rise;
  logic       exp_fall;
  logic       level;

  typedef struct {
    logic rst;
    logic pclk;
    logic exp_rise;
    logic exp_fall;
    logic exp_lock;
  } vec_t;
  vec_t vecs [12];

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40)
        $display("[TB] FAIL %s actual=%0d expected=%0d cyc=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic bit lastRunEqual(input int i);
    if (ivl_n[i] < LC) return 1'b0;
    for (int k = 1; k < LC; k++) begin
      if (ivl[i][ivl_n[i]-1-k] != ivl[i][ivl_n[i]-1]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic pushInterval(input int i, input int v);
    if (ivl_n[i] == 16) begin
      for (int k = 0; k < 15; k++) ivl[i][k] = ivl[i][k+1];
      ivl[i][15] = v;
    end else begin
      ivl[i][ivl_n[i]] = v;
      ivl_n[i]++;
    end
  endtask

  task automatic fsmModel(input int i, input bit e, input int half);
    int dev;
    case (mst[i])
      M_IDLE, M_LOST: begin
        if (e) begin
          mst[i]   = M_ACQ;
          ivl_n[i] = 0;
        end
      end
      M_ACQ: begin
        if (e) begin
          pushInterval(i, half);
          if (lastRunEqual(i)) begin
            mst[i]    = M_LOCKED;
            meas_m[i] = half;
          end
        end else if (half == int'(TO) - 1) begin
          mst[i] = M_LOST;
        end
      end
      M_LOCKED: begin
        if (e) begin
          dev = (half > meas_m[i]) ? half - meas_m[i] : meas_m[i] - half;
          if (dev > tol_m[i]) begin
            mst[i]   = M_ACQ;
            ivl_n[i] = 0;
            pushInterval(i, half);
          end
        end else if (half == int'(TO) - 1) begin
          mst[i] = M_LOST;
        end
      end
      default: ;
    endcase
  endtask

  task automatic modelStep(input logic r, input logic p);
    int  half;
    bit  e;
    cyc++;
    if (r) begin
      hist      = '0;
      last_edge = cyc - 1;
      exp_rise  = 1'b0;
      exp_fall  = 1'b0;
      for (int i = 0; i < 2; i++) begin
        mst[i]    = M_IDLE;
        meas_m[i] = 0;
        ivl_n[i]  = 0;
      end
      return;
    end
    hist     = {hist[3:0], p};
    exp_rise = hist[2] & ~hist[3];
    exp_fall = ~hist[2] & hist[3];
    e        = hist[3] ^ hist[4];
    half     = (cyc - 1) - last_edge - 1;
    if (half > 65535) half = 65535;
    for (int i = 0; i < 2; i++) fsmModel(i, e, half);
    if (e) last_edge = cyc - 1;
  endtask

  task automatic checkOutput();
    for (int i = 0; i < 2; i++) begin
      checkVal($sformatf("rise%0d", i), int'(rise_s[i]), int'(exp_rise));
      checkVal($sformatf("fall%0d", i), int'(fall_s[i]), int'(exp_fall));
      checkVal($sformatf("lock%0d", i), int'(lock_s[i]), (mst[i] == M_LOCKED) ? 1 : 0);
      checkVal($sformatf("lost%0d", i), int'(lost_s[i]), (mst[i] == M_LOST) ? 1 : 0);
      checkVal($sformatf("meas%0d", i), int'(meas_s[i]), meas_m[i]);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic p);
    rst     = r;
    pclk_in = p;
    @(posedge clk);
    modelStep(r, p);
    #1;
    checkOutput();
  endtask

  task automatic toggleAfter(input int len);
    repeat (len) applyStimulus(1'b0, level);
    level = ~level;
  endtask

  task automatic runDivide(input int d, input int halves);
    repeat (halves) toggleAfter(d + 1);
  endtask

  task automatic holdLevel(input int len);
    repeat (len) applyStimulus(1'b0, level);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    last_edge = 0;
    hist      = '0;
    level     = 1'b0;
    tol_m[0]  = 0;
    tol_m[1]  = 1;
    rst       = 1'b1;
    pclk_in   = 1'b0;

    // Strobe latency table: a change sampled on edge k shows as a strobe after edge k+2.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (3) applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checkVal("reset_lock", int'(lock_s[i]), 0);
      checkVal("reset_lost", int'(lost_s[i]), 0);
      checkVal("reset_meas", int'(meas_s[i]), 0);
      checkVal("reset_rise", int'(rise_s[i]), 0);
    end

    for (int v = 0; v < 12; v++) begin
      applyStimulus(vecs[v].rst, vecs[v].pclk);
      checkVal("tbl_rise", int'(rise_s[0]), int'(vecs[v].exp_rise));
      checkVal("tbl_fall", int'(fall_s[0]), int'(vecs[v].exp_fall));
      checkVal("tbl_lock", int'(lock_s[0]), int'(vecs[v].exp_lock));
    end
    level = 1'b0;

    $display("[TB] directed: lock at divide 4");
    applyStimulus(1'b1, 1'b0);
    runDivide(4, 10);
    checkVal("d4_lock", int'(lock_s[0]), 1);
    checkVal("d4_meas", int'(meas_s[0]), 4);

    $display("[TB] directed: retarget to divide 9");
    runDivide(9, 8);
    checkVal("d9_lock", int'(lock_s[0]), 1);
    checkVal("d9_meas", int'(meas_s[0]), 9);

    $display("[TB] directed: tolerance");
    runDivide(4, 10);
    checkVal("tol_base_lock", int'(lock_s[1]), 1);
    toggleAfter(6);
    runDivide(4, 2);
    checkVal("tol1_keep_lock", int'(lock_s[1]), 1);
    checkVal("tol0_drop_lock", int'(lock_s[0]), 0);
    runDivide(4, 8);
    toggleAfter(8);
    runDivide(4, 2);
    checkVal("tol1_drop_lock", int'(lock_s[1]), 0);
    runDivide(4, 8);
    checkVal("tol_relock", int'(lock_s[1]), 1);

    $display("[TB] directed: timeout");
    holdLevel(int'(TO) + 6);
    checkVal("to_lost", int'(lost_s[0]), 1);
    checkVal("to_lock", int'(lock_s[0]), 0);
    checkVal("to_meas", int'(meas_s[0]), 4);
    level = ~level;
    runDivide(4, 2);
    checkVal("to_recover_lost", int'(lost_s[0]), 0);
    runDivide(4, 8);

    $display("[TB] directed: divide 0");
    runDivide(0, 12);
    checkVal("d0_lock", int'(lock_s[0]), 1);
    checkVal("d0_meas", int'(meas_s[0]), 0);

    $display("[TB] directed: reset while locked");
    runDivide(4, 10);
    level = 1'b1;
    applyStimulus(1'b1, level);
    checkVal("rst_lock", int'(lock_s[0]), 0);
    checkVal("rst_meas", int'(meas_s[0]), 0);
    checkVal("rst_lost", int'(lost_s[0]), 0);
    runDivide(4, 10);
    checkVal("post_rst_lock", int'(lock_s[0]), 1);
    checkVal("post_rst_meas", int'(meas_s[0]), 4);

    $display("[TB] random stimulus");
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: runDivide(int'($urandom_range(0, 12)), int'($urandom_range(2, 12)));
        3:       toggleAfter(int'($urandom_range(1, 15)));
        4:       begin
                   holdLevel(int'($urandom_range(int'(TO) - 3, int'(TO) + 3)));
                   level = ~level;
                 end
        default: begin
                   level = 1'($urandom_range(0, 1));
                   applyStimulus(1'b1, level);
                 end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
